control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//   Hardwired Moore FSM that sequences the datapath's register-transfer strobes through fetch (T0-T2)
//   and execute (T3-T5) for register-register ALU instructions. Sits beside the datapath.
//   Decodes IR and drives PCout/MARin/Zin/.../Gra/Grb/Grc/Rin/Rout, replacing hand-driven testbench strobes.
// PARAMETERS
//   IR_WIDTH   32  instruction width; opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
//   WAIT_MAX   15  max cycles T1 may stall on mem_ready before abort (counter width = $clog2(WAIT_MAX+1))
// PORTS
//   clock      in   1   system clock, all state on rising edge
//   reset      in   1   asynchronous, active-high; forces IDLE
//   run        in   1   level; permits starting a new fetch
//   mem_ready  in   1   memory has Mdatain valid for current Read
//   ir         in   IR_WIDTH  IR register contents (valid from T3 on)
//   PCout,Zlowout,MDRout,MARin,Zin,PCin,MDRin,IRin,Yin,IncPC,Read  out 1 each  datapath strobes
//   Gra,Grb,Grc,Rin,Rout  out 1 each  select-and-encode controls (field select + enable)
//   alu_op     out  5   ALU operation; = ir opcode in T4, else 0
//   halted     out  1   high while in HALT
//   illegal_op out  1   one-cycle pulse in T3 on unsupported opcode
//   mem_err    out  1   one-cycle pulse on T1 stall timeout
// BEHAVIOUR
//   Reset (async, any state, mid-instruction included): state=IDLE, wait counter=0, every output 0.
//   Outputs decoded from state register only (Moore); one state per clock unless noted.
//   IDLE: no strobes. run=1 -> T0, else stay.
//   T0: PCout, MARin, IncPC, Zin -> T1.
//   T1: Zlowout, PCin, Read, MDRin asserted every cycle while in T1. PC update repeats harmlessly (same Z).
//       mem_ready=1 -> T2, counter cleared. mem_ready=0 -> stay, counter++.
//       counter==WAIT_MAX and mem_ready=0 -> pulse mem_err, go IDLE (mem_ready wins on the same cycle).
//   T2: MDRout, IRin -> T3.
//   T3: decode opcode.
//       ALU ops {3 add,4 sub,5 and,6 or,7 shr,8 shra,9 shl,10 ror,11 rol}: Grb, Rout, Yin -> T4.
//       nop (26): no strobes -> T0 if run else IDLE.
//       halt (27): no strobes -> HALT.
//       any other: illegal_op=1 for this cycle, treated as nop.
//   T4: Grc, Rout, Zin, alu_op=opcode -> T5.
//   T5: Zlowout, Gra, Rin -> T0 if run else IDLE (back-to-back, no bubble).
//   HALT: halted=1, no strobes; exits only via reset (run ignored).
//   run sampled only in IDLE/T3(nop)/T5; dropping run mid-instruction completes the instruction.
//   Never two bus drivers (PCout/Zlowout/MDRout/Rout) in one state.
// CONFIGURATION
//   CU_STEP_EN defined: new state STEP replaces the T5/nop -> T0 edge. Enter STEP instead of T0.
//     STEP: no strobes. run rising edge (registered previous-run, 0->1) -> T0.
//     run held high does not advance; reset clears the edge detector.
//   CU_STEP_EN undefined: no STEP state or edge register; behaviour exactly as above.
// TESTING
//   1 reset pulsed mid-T4 -> all outputs 0 asynchronously, state IDLE, next fetch starts only after run=1.
//   2 run=1, mem_ready=1, ir=32'h28918000 (and R1,R2,R3) -> sequence T0..T5 in 6 cycles.
//     T3 Grb+Rout+Yin; T4 Grc+Rout+Zin, alu_op=5; T5 Gra+Rin.
//   3 mem_ready low 3 cycles in T1 -> Read/MDRin held 4 cycles, then T2. No mem_err.
//     Low for WAIT_MAX+1 cycles -> mem_err pulse, IDLE.
//   4 ir opcode 27 (32'hD8000000) -> after T3 halted=1 permanently; run toggling ignored until reset.
//   5 ir opcode 20 -> illegal_op single pulse in T3, no Yin/Zin. With run=1, next T0 follows.
//   6 CU_STEP_EN: run held 1 -> stops in STEP after T5. Toggle run 0->1 -> exactly one more instruction.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hardwired Moore FSM sequencing fetch (T0-T2) and register-register ALU execute (T3-T5)
//   Parameters: IR_WIDTH (instruction width, opcode in the top 5 bits), WAIT_MAX (T1 stall limit)
//   Inputs : clock, reset (async, active-high), run (level start permit), mem_ready, ir
//   Outputs: PCout Zlowout MDRout MARin Zin PCin MDRin IRin Yin IncPC Read (datapath strobes),
//            Gra Grb Grc Rin Rout (select-and-encode), alu_op, halted, illegal_op, mem_err
//   Build option: define CU_STEP_EN to pause in STEP after each instruction until a run rising edge.
module control_unit #(
    parameter int IR_WIDTH = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [IR_WIDTH-1:0] ir,
    output logic                PCout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                MARin,
    output logic                Zin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                IncPC,
    output logic                Read,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [4:0]          alu_op,
    output logic                halted,
    output logic                illegal_op,
    output logic                mem_err
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;
`ifdef CU_STEP_EN
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT, STEP} state_t;
`else
    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;
`endif
    state_t          state_q, state_d, fetch_next;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_err_q, mem_err_d;
    logic [4:0]      opcode;
    logic            is_alu;
    logic            unused_ir;
    // Register fields are consumed by the datapath's select-and-encode logic, not here.
    assign opcode    = ir[IR_WIDTH-1 -: 5];
    assign unused_ir = ^ir[IR_WIDTH-6:0];
    assign is_alu    = (opcode >= 5'd3) && (opcode <= 5'd11);
    assign mem_err   = mem_err_q;
`ifdef CU_STEP_EN
    logic run_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) run_q <= 1'b0;
        else       run_q <= run;
    end
    // Completed instructions park in STEP; only a fresh run edge releases the next one.
    assign fetch_next = run ? STEP : IDLE;
`else
    assign fetch_next = run ? T0 : IDLE;
`endif
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        mem_err_d  = 1'b0;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        alu_op     = 5'd0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            IDLE: state_d = run ? T0 : IDLE;
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = T1;
            end
            T1: begin
                // PC reload from Z repeats every stall cycle; Z is unchanged so it is harmless.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) state_d = T2;
                else if (cnt_q == CW'(WAIT_MAX)) begin
                    mem_err_d = 1'b1;
                    state_d   = IDLE;
                end else cnt_d = cnt_q + CW'(1);
            end
            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end
            T3: begin
                if (is_alu) begin
                    Grb     = 1'b1;
                    Rout    = 1'b1;
                    Yin     = 1'b1;
                    state_d = T4;
                end else if (opcode == OP_HALT) state_d = HALT;
                else begin
                    illegal_op = (opcode != OP_NOP);
                    state_d    = fetch_next;
                end
            end
            T4: begin
                Grc     = 1'b1;
                Rout    = 1'b1;
                Zin     = 1'b1;
                alu_op  = opcode;
                state_d = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
                state_d = fetch_next;
            end
            HALT: halted = 1'b1;
`ifdef CU_STEP_EN
            STEP: state_d = (run && !run_q) ? T0 : STEP;
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit
module tb_control_unit;
    logic        clock = 1'b0;
    logic        reset, run, mem_ready;
    logic [31:0] ir;
    logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic        Gra, Grb, Grc, Rin, Rout, halted, illegal_op, mem_err;
    logic [4:0]  alu_op;
    logic [18:0] sig;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] IR_AND  = 32'h28918000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_ILL  = 32'hA0000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;

    // bit positions inside sig
    localparam logic [18:0] S_IDLE = 19'd0;
    localparam logic [18:0] S_T0   = (19'd1 << 18) | (19'd1 << 15) | (19'd1 << 9) | (19'd1 << 14);
    localparam logic [18:0] S_T1   = (19'd1 << 17) | (19'd1 << 13) | (19'd1 << 8) | (19'd1 << 12);
    localparam logic [18:0] S_T2   = (19'd1 << 16) | (19'd1 << 11);
    localparam logic [18:0] S_T3A  = (19'd1 << 6) | (19'd1 << 3) | (19'd1 << 10);
    localparam logic [18:0] S_T4   = (19'd1 << 5) | (19'd1 << 3) | (19'd1 << 14);
    localparam logic [18:0] S_T5   = (19'd1 << 17) | (19'd1 << 7) | (19'd1 << 4);
    localparam logic [18:0] S_HALT = 19'd1 << 2;
    localparam logic [18:0] S_ILL  = 19'd1 << 1;
    localparam logic [18:0] S_MERR = 19'd1;

    always #5 clock = ~clock;

    assign sig = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
                  Gra, Grb, Grc, Rin, Rout, halted, illegal_op, mem_err};

    control_unit dut (
        .clock(clock), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
        .halted(halted), .illegal_op(illegal_op), .mem_err(mem_err)
    );

    task automatic apply_reset;
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
        repeat (2) @(negedge clock);
        checks++;
        if (sig !== S_IDLE || alu_op !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%0d expected %h/0", sig, alu_op, S_IDLE);
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (sig !== S_IDLE) begin
                errors++;
                $display("FAIL idle_no_run: got %h expected %h", sig, S_IDLE);
            end
        end
    endtask

    task automatic test_alu;
        logic [18:0] exp_s [6];
        exp_s = '{S_T0, S_T1, S_T2, S_T3A, S_T4, S_T5};
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_AND;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if (sig !== exp_s[i]) begin
                errors++;
                $display("FAIL alu_seq[%0d]: got %h expected %h", i, sig, exp_s[i]);
            end
            checks++;
            if (alu_op !== ((i == 4) ? 5'd5 : 5'd0)) begin
                errors++;
                $display("FAIL alu_op[%0d]: got %0d expected %0d", i, alu_op, (i == 4) ? 5 : 0);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_async_reset;
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_AND;
        repeat (5) @(negedge clock);
        checks++;
        if (sig !== S_T4) begin
            errors++;
            $display("FAIL pre_reset_t4: got %h expected %h", sig, S_T4);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (sig !== S_IDLE || alu_op !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: got %h/%0d expected %h/0", sig, alu_op, S_IDLE);
        end
        @(negedge clock);
        reset = 1'b0; run = 1'b0;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (sig !== S_IDLE) begin
                errors++;
                $display("FAIL post_reset_idle: got %h expected %h", sig, S_IDLE);
            end
        end
        run = 1'b1;
        @(negedge clock);
        checks++;
        if (sig !== S_T0) begin
            errors++;
            $display("FAIL post_reset_fetch: got %h expected %h", sig, S_T0);
        end
        run = 1'b0;
    endtask

    task automatic test_mem_wait;
        apply_reset();
        run = 1'b1; mem_ready = 1'b0; ir = IR_AND;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (sig !== S_T1) begin
                errors++;
                $display("FAIL wait3_t1[%0d]: got %h expected %h", i, sig, S_T1);
            end
            if (i == 3) mem_ready = 1'b1;
        end
        @(negedge clock);
        checks++;
        if (sig !== S_T2) begin
            errors++;
            $display("FAIL wait3_t2: got %h expected %h", sig, S_T2);
        end
        apply_reset();
        run = 1'b1; ir = IR_AND;
        @(negedge clock);
        run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            checks++;
            if (sig !== S_T1) begin
                errors++;
                $display("FAIL edge_t1[%0d]: got %h expected %h", i, sig, S_T1);
            end
            if (i == 15) mem_ready = 1'b1;
        end
        @(negedge clock);
        checks++;
        if (sig !== S_T2) begin
            errors++;
            $display("FAIL ready_wins: got %h expected %h", sig, S_T2);
        end
        apply_reset();
        run = 1'b1; ir = IR_AND;
        @(negedge clock);
        run = 1'b0;
        repeat (16) @(negedge clock);
        checks++;
        if (sig !== S_T1) begin
            errors++;
            $display("FAIL timeout_last_t1: got %h expected %h", sig, S_T1);
        end
        @(negedge clock);
        checks++;
        if (sig !== S_MERR) begin
            errors++;
            $display("FAIL timeout_err: got %h expected %h", sig, S_MERR);
        end
        @(negedge clock);
        checks++;
        if (sig !== S_IDLE) begin
            errors++;
            $display("FAIL timeout_idle: got %h expected %h", sig, S_IDLE);
        end
    endtask

    task automatic test_halt;
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_HALT;
        repeat (4) @(negedge clock);
        checks++;
        if (sig !== S_IDLE) begin
            errors++;
            $display("FAIL halt_t3: got %h expected %h", sig, S_IDLE);
        end
        for (int i = 0; i < 5; i++) begin
            run = i[0];
            @(negedge clock);
            checks++;
            if (sig !== S_HALT) begin
                errors++;
                $display("FAIL halted[%0d]: got %h expected %h", i, sig, S_HALT);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (sig !== S_IDLE) begin
            errors++;
            $display("FAIL halt_reset: got %h expected %h", sig, S_IDLE);
        end
        @(negedge clock);
        reset = 1'b0; run = 1'b0;
    endtask

    task automatic test_illegal;
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_ILL;
        repeat (4) @(negedge clock);
        checks++;
        if (sig !== S_ILL) begin
            errors++;
            $display("FAIL illegal_t3: got %h expected %h", sig, S_ILL);
        end
        @(negedge clock);
        checks++;
`ifdef CU_STEP_EN
        if (sig !== S_IDLE) begin
            errors++;
            $display("FAIL illegal_next: got %h expected %h", sig, S_IDLE);
        end
`else
        if (sig !== S_T0) begin
            errors++;
            $display("FAIL illegal_next: got %h expected %h", sig, S_T0);
        end
`endif
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_NOP;
        repeat (3) @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        checks++;
        if (sig !== S_IDLE) begin
            errors++;
            $display("FAIL nop_t3: got %h expected %h", sig, S_IDLE);
        end
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (sig !== S_IDLE) begin
                errors++;
                $display("FAIL nop_idle: got %h expected %h", sig, S_IDLE);
            end
        end
    endtask

`ifndef CU_STEP_EN
    task automatic test_back_to_back;
        logic [18:0] exp_s [14];
        exp_s = '{S_T0, S_T1, S_T2, S_T3A, S_T4, S_T5, S_T0, S_T1, S_T2, S_T3A, S_T4, S_T5,
                  S_IDLE, S_IDLE};
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_AND;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            checks++;
            if (sig !== exp_s[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, sig, exp_s[i]);
            end
            if (i == 6) run = 1'b0;
        end
    endtask
`else
    task automatic test_step;
        logic [18:0] exp_s [6];
        exp_s = '{S_T0, S_T1, S_T2, S_T3A, S_T4, S_T5};
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_AND;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if (sig !== exp_s[i]) begin
                errors++;
                $display("FAIL step_first[%0d]: got %h expected %h", i, sig, exp_s[i]);
            end
        end
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (sig !== S_IDLE) begin
                errors++;
                $display("FAIL step_hold: got %h expected %h", sig, S_IDLE);
            end
        end
        run = 1'b0;
        @(negedge clock);
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if (sig !== exp_s[i]) begin
                errors++;
                $display("FAIL step_second[%0d]: got %h expected %h", i, sig, exp_s[i]);
            end
        end
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (sig !== S_IDLE) begin
                errors++;
                $display("FAIL step_park: got %h expected %h", sig, S_IDLE);
            end
        end
        run = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_async_reset();
        test_mem_wait();
        test_halt();
        test_illegal();
`ifndef CU_STEP_EN
        test_back_to_back();
`else
        test_step();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
